led_cycle_monitor: RTL
======================

# led_cycle_monitor

Receive-side checker for the 8-LED ping-pong pattern driven onto `lights` by the LED cycle block. Each clock it samples the 8-bit pattern and decodes the lit position and sweep direction. It flags any departure from the legal sequence 01→02→…→80→40→…→02→01 and keeps error and completed-sweep counts. It sits beside the LED driver in the top level, on the same slow `custom_clk`, and feeds debug LEDs / HEX displays.

## Interface
- `CNT_W`, default 8: width of `error_count` and `sweep_count`.

Ports:
- `custom_clk` input 1: the single clock, rising-edge; the same clock that advances the LED driver.
- `reset` input 1: asynchronous, active-high reset.
- `lights` input 8: pattern under test, driver-registered; only bit k lit means position k.
- `locked` output 1: monitor is synchronised to the sequence.
- `position` output 3: decoded lit index; valid only while `locked`=1.
- `direction` output 1: 0 = moving toward bit 7, 1 = moving toward bit 0; valid only while `locked`=1.
- `error` output 1: one-cycle pulse on each detected violation.
- `error_count` output CNT_W: violations since reset; saturates at all-ones.
- `sweep_count` output CNT_W: completed round trips since reset; wraps.

## Operation
- FSM states: UNLOCKED, LOCKED. The reset state is UNLOCKED.
- UNLOCKED:
  - `lights`=8'h01 → LOCKED, `position`=0, `direction`=0.
  - `lights`=8'h80 → LOCKED, `position`=7, `direction`=1.
  - Any other value, legal one-hot or not, is ignored: no error, stay UNLOCKED. Mid-sweep direction is ambiguous, so lock happens only at the ends.
- LOCKED, expected next value from the current (`position` p, `direction` d):
  - d=0, p<7 → p+1; d=0, p=7 → 6 with d←1.
  - d=1, p>0 → p-1; d=1, p=0 → 1 with d←0.
  - Sample equals expected one-hot → update p and d.
  - Sample is any other value (zero, multi-hot, wrong one-hot) → `error`=1, increment `error_count` (saturating), go to UNLOCKED.
- `sweep_count` increments when, in LOCKED, a sample of 8'h01 is accepted after 8'h02 (d=1→0 turnaround at bit 0). Initial lock on 8'h01 does not count.
- On a violation:
  - The errant sample is not evaluated for relock in the same cycle; relock needs a later 01/80.
  - `locked` drops to 0 in the same cycle `error` rises.
  - `position` and `direction` hold their last values, which are don't-care while unlocked.
- Arithmetic:
  - `error_count` saturates at 2^CNT_W−1.
  - `sweep_count` wraps modulo 2^CNT_W.
  - Both counters persist across lock/unlock cycles; only reset clears them.

## Timing
- All outputs are registered. A sample present before rising edge k is reflected on outputs right after edge k, i.e. one-edge latency.
- Because the driver updates `lights` on the same edge, the monitor judges the pattern produced by the previous edge. No combinational path from `lights` to any output.
- `error` is high for exactly one cycle per violating sample. Consecutive violating samples only occur while UNLOCKED, where they are ignored, so a second pulse needs a relock first.
- `reset` asserted at any time, including mid-sweep: all outputs go to 0 immediately (state UNLOCKED, counts 0, `position` 0, `direction` 0). Normal sampling resumes on the first edge after deassertion.

## Configuration
- `LED_MON_HOLD_EN`:
  - Defined: while LOCKED, a sample identical to the currently accepted pattern is a legal hold. No error, no state or count change. This allows sampling on a clock faster than the driver's.
  - Undefined: a repeated pattern is a mismatch and is flagged as a violation like any other.

## Test plan
- Reset, drive 01 then three round trips (02..80..02,01) → `locked`=1 one edge after first 01, `sweep_count`=3, `error_count`=0, `error` never high.
- Reset, start at 08 and sweep up → `locked` stays 0 with no error until 80 is sampled, then `locked`=1, `position`=7, `direction`=1.
- Locked at 04 (d=0), drive 8'h06 → one-cycle `error`, `error_count`=1, `locked`=0; next 01 relocks.
- Locked at 04 (d=0), drive 02 (premature reversal) → `error` pulse, `error_count` increments, `locked`=0.
- Locked at 10, drive 10 again → without `LED_MON_HOLD_EN`: `error`, `error_count`+1; with it: no error, `position`=4 holds.
- Force 300 violation/relock pairs, assert `reset` mid-sweep → `error_count` stops at 255; on reset all outputs are 0 before the next edge.

Source files
------------

// File: rtl/led_cycle_monitor.sv
// Receive-side checker for the 8-LED ping-pong sweep: locks at either end, flags departures.
// Optional LED_MON_HOLD_EN: accept a repeated pattern while locked as a legal hold.
module led_cycle_monitor #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             custom_clk,
    input  logic             reset,
    input  logic [7:0]       lights,
    output logic             locked,
    output logic [2:0]       position,
    output logic             direction,
    output logic             error,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] sweep_count
);

    typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

    state_e           state_q, state_d;
    logic [2:0]       pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] sweep_cnt_q, sweep_cnt_d;

    logic [2:0] exp_pos;
    logic       exp_dir;
    logic [7:0] exp_lights;
    logic       hold_ok;

    // Next legal position; direction flips when an end is reached.
    always_comb begin
        exp_pos = pos_q;
        exp_dir = dir_q;
        if (!dir_q) begin
            if (pos_q == 3'd7) begin
                exp_pos = 3'd6;
                exp_dir = 1'b1;
            end else begin
                exp_pos = pos_q + 3'd1;
            end
        end else begin
            if (pos_q == 3'd0) begin
                exp_pos = 3'd1;
                exp_dir = 1'b0;
            end else begin
                exp_pos = pos_q - 3'd1;
            end
        end
        exp_lights = 8'd1 << exp_pos;
    end

`ifdef LED_MON_HOLD_EN
    always_comb hold_ok = (lights == (8'd1 << pos_q));
`else
    always_comb hold_ok = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        sweep_cnt_d = sweep_cnt_q;
        unique case (state_q)
            StUnlocked: begin
                if (lights == 8'h01) begin
                    state_d = StLocked;
                    pos_d   = 3'd0;
                    dir_d   = 1'b0;
                end else if (lights == 8'h80) begin
                    state_d = StLocked;
                    pos_d   = 3'd7;
                    dir_d   = 1'b1;
                end
            end
            StLocked: begin
                if (lights == exp_lights) begin
                    pos_d = exp_pos;
                    dir_d = exp_dir;
                    // Expected position 0 only arises from 02 moving down: a round trip ends.
                    if (exp_pos == 3'd0) begin
                        sweep_cnt_d = sweep_cnt_q + CNT_W'(1);
                    end
                end else if (!hold_ok) begin
                    state_d = StUnlocked;
                    err_d   = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StUnlocked;
        endcase
    end

    always_ff @(posedge custom_clk or posedge reset) begin
        if (reset) begin
            state_q     <= StUnlocked;
            pos_q       <= 3'd0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            sweep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    assign locked      = (state_q == StLocked);
    assign position    = pos_q;
    assign direction   = dir_q;
    assign error       = err_q;
    assign error_count = err_cnt_q;
    assign sweep_count = sweep_cnt_q;

endmodule
